unit_hazard: RTL and testbench

- Pipeline hazard/stall controller for the 5-stage MIPS core, paired with the EX-stage forwarding unit.
- Handles the cases bypassing cannot resolve:
  - load-use hazards;
  - ID-stage branch operand hazards;
  - structural/data hazards on the multi-cycle MUL/DIV unit (HI/LO).
- Drives the PC and IF/ID write enables, the ID/EX bubble and the IF/ID flush, and keeps a stall-cycle performance counter.

---
 rtl/unit_hazard.sv | 100 ++++++++++
 tb/tb_unit_hazard.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/unit_hazard.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use, ID-branch
// operand and MUL/DIV HI/LO hazards, plus a saturating stall-cycle counter.
module unit_hazard #(
    parameter int MULDIV_LATENCY = 4,
    parameter int STALL_CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             IFID_RegisterRs,
    input  logic [4:0]             IFID_RegisterRt,
    input  logic                   IFID_ReadsRt,
    input  logic                   IFID_Branch,
    input  logic                   IFID_BranchTaken,
    input  logic                   IFID_ReadsHiLo,
    input  logic                   IFID_MulDivStart,
    input  logic                   IDEX_MemRead,
    input  logic                   IDEX_RegWrite,
    input  logic [4:0]             IDEX_RegisterRd,
    input  logic                   EXMEM_MemRead,
    input  logic [4:0]             EXMEM_RegisterRd,
    output logic                   PC_Write,
    output logic                   IFID_Write,
    output logic                   IDEX_Bubble,
    output logic                   IFID_Flush,
    output logic                   MulDiv_Busy,
    output logic [STALL_CNT_W-1:0] Stall_Count
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [3:0] cnt;

    logic src_ex;
    logic src_mem;
    logic load_use;
    logic br_ex;
    logic br_mem;
    logic md_stall;
    logic stall;

    assign src_ex = (IDEX_RegisterRd != 5'd0) &&
                    ((IDEX_RegisterRd == IFID_RegisterRs) ||
                     (IFID_ReadsRt && (IDEX_RegisterRd == IFID_RegisterRt)));

    assign src_mem = (EXMEM_RegisterRd != 5'd0) &&
                     ((EXMEM_RegisterRd == IFID_RegisterRs) ||
                      (IFID_ReadsRt && (EXMEM_RegisterRd == IFID_RegisterRt)));

    assign load_use = IDEX_MemRead && src_ex;
    assign br_ex    = IFID_Branch && IDEX_RegWrite && src_ex;
    assign br_mem   = IFID_Branch && EXMEM_MemRead && src_mem;
    assign md_stall = MulDiv_Busy && (IFID_ReadsHiLo || IFID_MulDivStart);
    assign stall    = load_use | br_ex | br_mem | md_stall;

    // Reset holds the front end and clears IF/ID and ID/EX every cycle.
    assign PC_Write    = !rst && !stall;
    assign IFID_Write  = !rst && !stall;
    assign IDEX_Bubble = rst || stall;
    assign IFID_Flush  = rst || (IFID_BranchTaken && !stall);

    assign MulDiv_Busy = (state == BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (IFID_MulDivStart && !stall) begin
                        state <= BUSY;
                        cnt   <= 4'(MULDIV_LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Stall_Count <= '0;
        end else if (stall && (Stall_Count != {STALL_CNT_W{1'b1}})) begin
            Stall_Count <= Stall_Count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_unit_hazard.sv
// Directed bench for unit_hazard: vector table for the combinational
// hazard terms plus cycle sequences for branch, MUL/DIV, reset and saturation.
module tb_unit_hazard;

    logic        clk;
    logic        rst;
    logic [4:0]  rs, rt;
    logic        reads_rt, branch, taken, hilo, md_start;
    logic        ex_mr, ex_rw;
    logic [4:0]  ex_rd;
    logic        mem_mr;
    logic [4:0]  mem_rd;

    logic        pc_write, ifid_write, bubble, flush, busy;
    logic [31:0] cnt;
    logic        s_pcw, s_ifw, s_bub, s_fl, s_busy;
    logic [3:0]  s_cnt;

    int tests;
    int fails;
    int exp_cnt;
    int exp_sat;

    unit_hazard #(.MULDIV_LATENCY(4), .STALL_CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .IFID_RegisterRs(rs), .IFID_RegisterRt(rt),
        .IFID_ReadsRt(reads_rt), .IFID_Branch(branch),
        .IFID_BranchTaken(taken), .IFID_ReadsHiLo(hilo),
        .IFID_MulDivStart(md_start),
        .IDEX_MemRead(ex_mr), .IDEX_RegWrite(ex_rw), .IDEX_RegisterRd(ex_rd),
        .EXMEM_MemRead(mem_mr), .EXMEM_RegisterRd(mem_rd),
        .PC_Write(pc_write), .IFID_Write(ifid_write),
        .IDEX_Bubble(bubble), .IFID_Flush(flush),
        .MulDiv_Busy(busy), .Stall_Count(cnt)
    );

    unit_hazard #(.MULDIV_LATENCY(4), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .IFID_RegisterRs(rs), .IFID_RegisterRt(rt),
        .IFID_ReadsRt(reads_rt), .IFID_Branch(branch),
        .IFID_BranchTaken(taken), .IFID_ReadsHiLo(hilo),
        .IFID_MulDivStart(md_start),
        .IDEX_MemRead(ex_mr), .IDEX_RegWrite(ex_rw), .IDEX_RegisterRd(ex_rd),
        .EXMEM_MemRead(mem_mr), .EXMEM_RegisterRd(mem_rd),
        .PC_Write(s_pcw), .IFID_Write(s_ifw),
        .IDEX_Bubble(s_bub), .IFID_Flush(s_fl),
        .MulDiv_Busy(s_busy), .Stall_Count(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       reads_rt;
        logic       branch;
        logic       taken;
        logic       hilo;
        logic       ex_mr;
        logic       ex_rw;
        logic [4:0] ex_rd;
        logic       mem_mr;
        logic [4:0] mem_rd;
        logic       stall;
        logic       flush;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        rs = 0; rt = 0; reads_rt = 0; branch = 0; taken = 0;
        hilo = 0; md_start = 0; ex_mr = 0; ex_rw = 0; ex_rd = 0;
        mem_mr = 0; mem_rd = 0;
    endtask

    // Inputs are already driven; check outputs mid-cycle, then take the edge.
    task automatic cyc(input string name, input logic st, input logic fl,
                       input logic bz);
        @(negedge clk);
        check({name, ".pc_write"}, 32'(pc_write), 32'(!st));
        check({name, ".ifid_write"}, 32'(ifid_write), 32'(!st));
        check({name, ".bubble"}, 32'(bubble), 32'(st));
        check({name, ".flush"}, 32'(flush), 32'(fl));
        check({name, ".busy"}, 32'(busy), 32'(bz));
        @(posedge clk);
        if (rst) begin
            exp_cnt = 0;
            exp_sat = 0;
        end else if (st) begin
            exp_cnt++;
            if (exp_sat != 15) exp_sat++;
        end
        #1;
    endtask

    initial begin
        tests = 0; fails = 0; exp_cnt = 0; exp_sat = 0;
        clear_in();
        rst = 1'b1;

        vt[0]  = '{"lu_rs",      5, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 1, 0};
        vt[1]  = '{"lu_r0",      0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vt[2]  = '{"lu_rt",      1, 7, 1, 0, 0, 0, 1, 1, 7, 0, 0, 1, 0};
        vt[3]  = '{"lu_rt_unused", 1, 7, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0};
        vt[4]  = '{"alu_fwd",    3, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0};
        vt[5]  = '{"br_ex",      3, 0, 0, 1, 1, 0, 0, 1, 3, 0, 0, 1, 0};
        vt[6]  = '{"br_mem",     2, 9, 1, 1, 1, 0, 0, 0, 0, 1, 9, 1, 0};
        vt[7]  = '{"br_mem_alu", 2, 9, 1, 1, 1, 0, 0, 0, 0, 0, 9, 0, 1};
        vt[8]  = '{"taken",      0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[9]  = '{"multi",      4, 6, 1, 1, 1, 0, 1, 1, 4, 1, 6, 1, 0};
        vt[10] = '{"hilo_idle",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{"br_r0",      0, 0, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 1};

        @(posedge clk); #1;
        cyc("reset", 1, 1, 0);
        rst = 1'b0;
        cyc("post_reset", 0, 0, 0);
        check("reset.cnt", cnt, 0);

        for (int i = 0; i < 12; i++) begin
            rs = vt[i].rs; rt = vt[i].rt; reads_rt = vt[i].reads_rt;
            branch = vt[i].branch; taken = vt[i].taken; hilo = vt[i].hilo;
            ex_mr = vt[i].ex_mr; ex_rw = vt[i].ex_rw; ex_rd = vt[i].ex_rd;
            mem_mr = vt[i].mem_mr; mem_rd = vt[i].mem_rd;
            cyc(vt[i].name, vt[i].stall, vt[i].flush, 0);
            check({vt[i].name, ".cnt"}, cnt, 32'(exp_cnt));
        end
        clear_in();
        check("table.cnt_abs", cnt, 5);

        // lw $8 in EX, beq on $8 in ID: two stall cycles, then taken flush
        rs = 8; branch = 1; taken = 1;
        ex_mr = 1; ex_rw = 1; ex_rd = 8;
        cyc("bl_c1", 1, 0, 0);
        ex_mr = 0; ex_rw = 0; ex_rd = 0; mem_mr = 1; mem_rd = 8;
        cyc("bl_c2", 1, 0, 0);
        mem_mr = 0; mem_rd = 0;
        cyc("bl_c3", 0, 1, 0);
        check("bl.cnt", cnt, 7);
        clear_in();

        // mult at t, mflo at t+1 stalls through t+3
        md_start = 1;
        cyc("md_t", 0, 0, 0);
        md_start = 0; hilo = 1;
        cyc("md_t1", 1, 0, 1);
        cyc("md_t2", 1, 0, 1);
        cyc("md_t3", 1, 0, 1);
        cyc("md_t4", 0, 0, 0);
        clear_in();

        // second mult at t+2 waits until t+4, then is accepted
        md_start = 1;
        cyc("m2_t", 0, 0, 0);
        md_start = 0;
        cyc("m2_t1", 0, 0, 1);
        md_start = 1;
        cyc("m2_t2", 1, 0, 1);
        cyc("m2_t3", 1, 0, 1);
        cyc("m2_t4", 0, 0, 0);
        md_start = 0;
        cyc("m2_t5", 0, 0, 1);
        cyc("m2_t6", 0, 0, 1);
        cyc("m2_t7", 0, 0, 1);
        cyc("m2_t8", 0, 0, 0);
        check("md.cnt", cnt, 32'(exp_cnt));

        // start coinciding with load-use is deferred one cycle
        md_start = 1; ex_mr = 1; ex_rd = 5; rs = 5;
        cyc("sv_c0", 1, 0, 0);
        ex_mr = 0; ex_rd = 0; rs = 0;
        cyc("sv_c1", 0, 0, 0);
        md_start = 0;
        cyc("sv_c2", 0, 0, 1);
        cyc("sv_c3", 0, 0, 1);
        cyc("sv_c4", 0, 0, 1);
        cyc("sv_c5", 0, 0, 0);

        // reset two cycles after an accepted mult
        md_start = 1;
        cyc("rb_t", 0, 0, 0);
        md_start = 0;
        cyc("rb_t1", 0, 0, 1);
        rst = 1;
        cyc("rb_t2", 1, 1, 1);
        rst = 0;
        cyc("rb_t3", 0, 0, 0);
        check("rb.cnt", cnt, 0);
        check("rb.sat_cnt", 32'(s_cnt), 0);

        // 20 load-use cycles: 4-bit counter pins at F, 32-bit one keeps going
        ex_mr = 1; ex_rd = 12; rs = 12;
        for (int i = 0; i < 20; i++) begin
            cyc("sat", 1, 0, 0);
            check("sat.cnt4", 32'(s_cnt), 32'(exp_sat));
        end
        clear_in();
        check("sat.final4", 32'(s_cnt), 32'hF);
        check("sat.final32", cnt, 20);
        cyc("sat_idle", 0, 0, 0);
        check("sat.hold4", 32'(s_cnt), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
